// File: rtl/uart_pkt_rx_if.sv
// Byte-strobe input and packet valid/ready output bundle of the UART packet deframer.
// The slave modport is the deframer's view; the master modport is the byte source plus the packet consumer.
interface uart_pkt_rx_if #(
    parameter int MAX_LEN = 16
);
    logic [7:0]           RX_DATA;
    logic                 RX_RECV;
    logic [7:0]           PKT_CMD;
    logic [7:0]           PKT_LEN;
    logic [8*MAX_LEN-1:0] PKT_DATA;
    logic                 PKT_VALID;
    logic                 PKT_READY;
    logic                 ERR_LEN;
    logic                 ERR_TIMEOUT;
    logic                 ERR_OVERRUN;

    modport master (
        output RX_DATA, RX_RECV, PKT_READY,
        input  PKT_CMD, PKT_LEN, PKT_DATA, PKT_VALID, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN
    );

    modport slave (
        input  RX_DATA, RX_RECV, PKT_READY,
        output PKT_CMD, PKT_LEN, PKT_DATA, PKT_VALID, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN
    );
endinterface

// File: rtl/uart_pkt_rx.sv
// UART receive deframer: buffers single-byte strobes in a small FIFO and parses
// FF, CMD, LEN, DATA[LEN] frames into packets presented on a valid/ready handshake.
module uart_pkt_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic         CLK,
    input logic         RST,
    uart_pkt_rx_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PW    = 8 * MAX_LEN;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {HUNT, CMD, LEN, DATA, OUT} state_t;

    state_t            state, state_nxt;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [7:0]        cmd_q, cmd_nxt;
    logic [7:0]        len_q, len_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic [PW-1:0]     pay_q, pay_nxt;
    logic [TO_W-1:0]   to_q, to_nxt;
    logic              empty, full, pop, push;
    logic              err_len, err_to;
    logic [7:0]        byte_rd;

    // The extra pointer bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = !empty && (state != OUT);
    assign push    = bus.RX_RECV && (!full || pop);
    assign byte_rd = mem[rd_ptr[PTR_W-1:0]];

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
        pay_nxt   = pay_q;
        to_nxt    = to_q;
        err_len   = 1'b0;
        err_to    = 1'b0;

        case (state)
            HUNT: if (pop && byte_rd == 8'hFF) state_nxt = CMD;
            CMD: if (pop) begin
                cmd_nxt   = byte_rd;
                state_nxt = LEN;
            end
            LEN: if (pop) begin
                len_nxt = byte_rd;
                pay_nxt = '0;
                cnt_nxt = 8'd0;
                if ({24'd0, byte_rd} > MAX_LEN) begin
                    err_len   = 1'b1;
                    state_nxt = HUNT;
                end else if (byte_rd == 8'd0) begin
                    state_nxt = OUT;
                end else begin
                    state_nxt = DATA;
                end
            end
            DATA: if (pop) begin
                pay_nxt = (pay_q << 8) | PW'(byte_rd);
                cnt_nxt = cnt_q + 8'd1;
                if (cnt_q + 8'd1 == len_q) state_nxt = OUT;
            end
            OUT: if (bus.PKT_READY) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase

        // Inside a frame, a non-popping cycle means the FIFO is empty, so the line has gone quiet.
        if (state == HUNT || state == OUT || pop) begin
            to_nxt = '0;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_to    = 1'b1;
            to_nxt    = '0;
            state_nxt = HUNT;
        end else begin
            to_nxt = to_q + TO_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= HUNT;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cmd_q  <= 8'd0;
            len_q  <= 8'd0;
            cnt_q  <= 8'd0;
            pay_q  <= '0;
            to_q   <= '0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_nxt;
            len_q <= len_nxt;
            cnt_q <= cnt_nxt;
            pay_q <= pay_nxt;
            to_q  <= to_nxt;
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= bus.RX_DATA;
    end

    // Combinational pulses are masked while reset is held so every output reads 0 in reset.
    assign bus.PKT_VALID   = (state == OUT) && !RST;
    assign bus.PKT_CMD     = cmd_q;
    assign bus.PKT_LEN     = len_q;
    assign bus.PKT_DATA    = pay_q;
    assign bus.ERR_LEN     = err_len && !RST;
    assign bus.ERR_TIMEOUT = err_to && !RST;
    assign bus.ERR_OVERRUN = bus.RX_RECV && full && !pop && !RST;
endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx: table of single frames plus hand-written
// sequences for back-pressure, overrun, timeout and mid-frame reset.
module tb_uart_pkt_rx;
    localparam int ML = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_pkt_rx_if #(.MAX_LEN(ML)) bus ();

    uart_pkt_rx #(.FIFO_DEPTH(4), .MAX_LEN(ML), .TIMEOUT_CYCLES(100)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0]   cmd;
        logic [7:0]   len;
        logic [127:0] data;
    } pkt_t;

    typedef struct {
        logic [159:0] frame;
        int           n;
        int           exp_pkts;
        logic [7:0]   cmd;
        logic [7:0]   len;
        logic [127:0] data;
        int           exp_errlen;
    } vec_t;

    pkt_t got[$];
    int   errors = 0, checks = 0;
    int   n_vld = 0, n_errlen = 0, n_to = 0, n_ov = 0, stab_err = 0;
    int   cyc = 0, to_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: handshakes, error pulse counts, and hold-stability of a presented packet.
    logic pv = 1'b0, pr = 1'b0;
    pkt_t prev;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (bus.PKT_VALID && bus.PKT_READY) begin
                pkt_t p;
                p.cmd = bus.PKT_CMD; p.len = bus.PKT_LEN; p.data = bus.PKT_DATA;
                got.push_back(p);
            end
            if (bus.PKT_VALID) n_vld++;
            if (bus.ERR_LEN) n_errlen++;
            if (bus.ERR_OVERRUN) n_ov++;
            if (bus.ERR_TIMEOUT) begin n_to++; to_cyc = cyc; end
            if (pv && !pr && (!bus.PKT_VALID || bus.PKT_CMD !== prev.cmd ||
                bus.PKT_LEN !== prev.len || bus.PKT_DATA !== prev.data)) stab_err++;
            pv = bus.PKT_VALID; pr = bus.PKT_READY;
            prev.cmd = bus.PKT_CMD; prev.len = bus.PKT_LEN; prev.data = bus.PKT_DATA;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at posedge+1; strobes for one cycle and returns at the next posedge+1.
    task automatic send_byte(input logic [7:0] b);
        bus.RX_DATA = b;
        bus.RX_RECV = 1'b1;
        @(posedge clk); #1;
        bus.RX_RECV = 1'b0;
        bus.RX_DATA = 8'h00;
    endtask

    task automatic send_frame(input logic [159:0] f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    vec_t vecs[8];

    initial begin
        int p0, e0, t0, o0, v0, s;

        vecs[0] = '{160'hFF0201A5, 4, 1, 8'h02, 8'h01, 128'hA5, 0};
        vecs[1] = '{160'h1234FF0402037F, 7, 1, 8'h04, 8'h02, 128'h037F, 0};
        vecs[2] = '{160'hFF0311, 3, 0, 8'h00, 8'h00, 128'h0, 1};
        vecs[3] = '{160'hFF030155, 4, 1, 8'h03, 8'h01, 128'h55, 0};
        vecs[4] = '{160'hFF0700, 3, 1, 8'h07, 8'h00, 128'h0, 0};
        vecs[5] = '{160'hFFFF03112233, 6, 1, 8'hFF, 8'h03, 128'h112233, 0};
        vecs[6] = '{160'hFF0910_0102030405060708090A0B0C0D0E0F10, 19, 1, 8'h09, 8'h10,
                    128'h0102030405060708090A0B0C0D0E0F10, 0};
        vecs[7] = '{160'hFF0512, 3, 0, 8'h00, 8'h00, 128'h0, 1};

        bus.RX_DATA   = 8'h00;
        bus.RX_RECV   = 1'b0;
        bus.PKT_READY = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        chk("reset_valid", 128'(bus.PKT_VALID), 128'd0);
        chk("reset_cmd", 128'(bus.PKT_CMD), 128'd0);
        chk("reset_len", 128'(bus.PKT_LEN), 128'd0);
        chk("reset_data", bus.PKT_DATA, 128'd0);
        chk("reset_errs", 128'({bus.ERR_LEN, bus.ERR_TIMEOUT, bus.ERR_OVERRUN}), 128'd0);

        foreach (vecs[k]) begin
            p0 = got.size(); e0 = n_errlen; t0 = n_to; o0 = n_ov; v0 = n_vld;
            send_frame(vecs[k].frame, vecs[k].n);
            idle(8);
            chk_int($sformatf("v%0d_pkts", k), got.size() - p0, vecs[k].exp_pkts);
            chk_int($sformatf("v%0d_vld_cycles", k), n_vld - v0, vecs[k].exp_pkts);
            chk_int($sformatf("v%0d_err_len", k), n_errlen - e0, vecs[k].exp_errlen);
            chk_int($sformatf("v%0d_other_errs", k), (n_to - t0) + (n_ov - o0), 0);
            if (vecs[k].exp_pkts == 1 && got.size() > p0) begin
                chk($sformatf("v%0d_cmd", k), 128'(got[$].cmd), 128'(vecs[k].cmd));
                chk($sformatf("v%0d_len", k), 128'(got[$].len), 128'(vecs[k].len));
                chk($sformatf("v%0d_data", k), got[$].data, vecs[k].data);
            end
        end

        // Back-pressure: two zero-length frames while the consumer stalls.
        bus.PKT_READY = 1'b0;
        p0 = got.size(); o0 = n_ov; s = stab_err;
        send_frame(160'hFF0000FF0100, 6);
        idle(20);
        chk("hold_valid", 128'(bus.PKT_VALID), 128'd1);
        chk("hold_cmd", 128'(bus.PKT_CMD), 128'h00);
        chk_int("hold_no_handshake", got.size() - p0, 0);
        bus.PKT_READY = 1'b1;
        idle(10);
        chk_int("hold_pkts", got.size() - p0, 2);
        if (got.size() - p0 == 2) begin
            chk("hold_first_cmd", 128'(got[p0].cmd), 128'h00);
            chk("hold_second_cmd", 128'(got[p0+1].cmd), 128'h01);
            chk("hold_second_len", 128'(got[p0+1].len), 128'h00);
        end
        chk_int("hold_overrun", n_ov - o0, 0);
        chk_int("hold_stable", stab_err - s, 0);

        // Overrun: five bytes into a four-entry FIFO while a packet is held.
        bus.PKT_READY = 1'b0;
        p0 = got.size(); o0 = n_ov;
        send_frame(160'hFF0000, 3);
        idle(4);
        send_frame(160'hFF06015A77, 5);
        idle(2);
        chk_int("ovr_pulses", n_ov - o0, 1);
        chk("ovr_valid_held", 128'(bus.PKT_VALID), 128'd1);
        bus.PKT_READY = 1'b1;
        @(posedge clk); #1;
        // FIFO is full and popping this cycle, so this write must be accepted.
        send_byte(8'hFF);
        send_frame(160'h0C00, 2);
        idle(15);
        chk_int("ovr_pkts", got.size() - p0, 3);
        if (got.size() - p0 == 3) begin
            chk("ovr_p1_cmd", 128'(got[p0+1].cmd), 128'h06);
            chk("ovr_p1_data", got[p0+1].data, 128'h5A);
            chk("ovr_p2_cmd", 128'(got[p0+2].cmd), 128'h0C);
        end
        chk_int("ovr_full_pop_write", n_ov - o0, 1);

        // Inter-byte timeout after FF 02.
        t0 = n_to; p0 = got.size();
        s = cyc;
        send_frame(160'hFF02, 2);
        for (int i = 0; i < 150 && n_to == t0; i++) begin @(posedge clk); #1; end
        idle(3);
        chk_int("to_pulses", n_to - t0, 1);
        chk_int("to_cycle", to_cyc - s, 102);
        chk("to_no_valid", 128'(bus.PKT_VALID), 128'd0);
        send_frame(160'hFF0D00, 3);
        idle(6);
        chk_int("to_then_pkt", got.size() - p0, 1);
        if (got.size() > p0) chk("to_then_cmd", 128'(got[$].cmd), 128'h0D);

        // Reset in the middle of a payload.
        p0 = got.size(); e0 = n_errlen; t0 = n_to; o0 = n_ov;
        send_frame(160'hFF0E0311, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_valid", 128'(bus.PKT_VALID), 128'd0);
        chk("rst_cmd", 128'(bus.PKT_CMD), 128'd0);
        chk("rst_len", 128'(bus.PKT_LEN), 128'd0);
        send_frame(160'h2233FF0F0144, 6);
        idle(8);
        chk_int("rst_pkts", got.size() - p0, 1);
        if (got.size() > p0) begin
            chk("rst_pkt_cmd", 128'(got[$].cmd), 128'h0F);
            chk("rst_pkt_data", got[$].data, 128'h44);
        end
        chk_int("rst_errs", (n_errlen - e0) + (n_to - t0) + (n_ov - o0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_pkt_rx.md
Name: uart_pkt_rx

Overview:
Receive-side packet deframer between uart_rx and the command handler in the board top level. Consumes single-byte strobes from uart_rx and buffers them in a small byte FIFO. Parses the frame 0xFF, CMD, LEN, DATA[LEN] and presents each complete packet on a valid/ready interface. Replaces the ad-hoc shift-register receive path so that no received byte is lost while the command handler or the transmit path is busy.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2.
MAX_LEN, 16, maximum payload bytes; the payload bus is 8*MAX_LEN bits wide.
TIMEOUT_CYCLES, 50000, idle clocks allowed between bytes inside a frame before the frame is aborted (1 ms at 50 MHz).

Ports:
CLK  in  1  system clock (CLOCK_50)
RST  in  1  synchronous, active-high reset
RX_DATA  in  8  byte from uart_rx; valid only while RX_RECV is high
RX_RECV  in  1  one-cycle strobe, byte available
PKT_CMD  out  8  command byte of the presented packet
PKT_LEN  out  8  payload length of the presented packet
PKT_DATA  out  8*MAX_LEN  payload; last received byte in [7:0], earlier bytes shifted up, unused upper bits 0
PKT_VALID  out  1  packet presented; held until accepted
PKT_READY  in  1  consumer accepts the packet when PKT_VALID and PKT_READY are both high
ERR_LEN  out  1  one-cycle pulse, LEN > MAX_LEN
ERR_TIMEOUT  out  1  one-cycle pulse, frame aborted by inter-byte timeout
ERR_OVERRUN  out  1  one-cycle pulse, byte dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in HUNT; timeout counter 0. Reset mid-frame discards the partial frame and all FIFO content.
- FIFO write: on RX_RECV, if the FIFO is not full, write RX_DATA; if it is full, drop the byte and pulse ERR_OVERRUN in the same cycle. A write to a full FIFO in the same cycle as a read is accepted (no overrun).
- FIFO read: at most one byte per cycle. A pop occurs only when the FIFO is not empty and the FSM is not in OUT. A byte written in cycle N can be popped in cycle N+1 at the earliest.
- FSM states HUNT, CMD, LEN, DATA, OUT. Transitions are evaluated on each popped byte:
  - HUNT: byte == 0xFF -> CMD; any other byte is discarded and the FSM stays in HUNT.
  - CMD: latch the CMD byte (0xFF is legal here) -> LEN.
  - LEN: latch the LEN byte; clear the payload register and byte count.
    - LEN > MAX_LEN -> pulse ERR_LEN, go to HUNT; the payload bytes that follow are consumed by HUNT.
    - LEN == 0 -> OUT with PKT_DATA = 0.
    - Otherwise -> DATA.
  - DATA: payload = (payload << 8) | byte; count++. When count reaches LEN -> OUT.
  - OUT: PKT_VALID = 1; PKT_CMD, PKT_LEN and PKT_DATA are stable. On PKT_READY -> HUNT, and PKT_VALID is 0 in the next cycle. Bytes arriving meanwhile are stored in the FIFO.
- Latency: PKT_VALID rises in the cycle after the last payload byte is popped, or after LEN when LEN == 0.
- Timeout:
  - The counter clears on every pop and whenever the FSM is in HUNT or OUT.
  - The counter increments in CMD, LEN and DATA while the FIFO is empty.
  - Reaching TIMEOUT_CYCLES: pulse ERR_TIMEOUT, go to HUNT, clear the counter.
- Error pulses are independent of each other; ERR_OVERRUN may coincide with any state.
- PKT_* outputs keep their last value outside OUT; only PKT_VALID qualifies them.

Test Plan:
- Reset then FF 02 01 A5 with PKT_READY=1 -> PKT_VALID one cycle, PKT_CMD=02, PKT_LEN=01, PKT_DATA=...00A5.
- Garbage 12 34 then FF 04 02 03 7F -> packet CMD=04, LEN=02, PKT_DATA[15:0]=037F; garbage produces no output and no error.
- PKT_READY=0 with two back-to-back frames FF 00 00 and FF 01 00 -> first packet held stable with PKT_VALID high; after 20 cycles assert PKT_READY -> second packet CMD=01, LEN=0 follows, no ERR_OVERRUN.
- PKT_READY=0, 5 extra bytes sent after a held packet with FIFO_DEPTH=4 -> exactly one ERR_OVERRUN pulse; after release, the four buffered bytes are parsed in order.
- FF 03 11 (LEN 17 > MAX_LEN) -> ERR_LEN pulse, no PKT_VALID; a following FF 03 01 55 is received correctly.
- FF 02 then silence, TIMEOUT_CYCLES=100 -> ERR_TIMEOUT 100 cycles after the last pop; FSM in HUNT. Assert RST during DATA of another frame -> PKT_VALID stays 0 and the next full frame parses normally.
